entrada_fun: RTL and testbench
==============================

ENTRADA_FUN -- requirements
Module: entrada_fun

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 1000, meaning cycles spent in MOSTRA before automatic return to ESP_A (0 = no timeout).
REQ-002 The block SHALL have parameter DEB_CYC, default 16, meaning consecutive stable cycles required by the debounce filter (used only with DEBOUNCE_EN).
REQ-003 The block SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port sw  input  3  functionality code from the user switches.
REQ-006 The block SHALL have port btn  input  1  raw confirm button, active-high, asynchronous to clk.
REQ-007 The block SHALL have port fun_a  output  3  first captured functionality code, driving comparator inputs A,B,C.
REQ-008 The block SHALL have port fun_b  output  3  second captured functionality code, driving comparator inputs D,E,F.
REQ-009 The block SHALL have port valid  output  1  both codes captured; comparator result is meaningful.
REQ-010 The block SHALL have port estado  output  2  current state encoding for the status LEDs.

Function
REQ-011 btn SHALL pass through a 2-flop synchronizer; a press SHALL be a one-cycle pulse on the rising edge of the synchronized (or filtered) level.
REQ-012 Without DEBOUNCE_EN, the state update for a press SHALL occur on the 3rd rising clk edge after btn rises.
REQ-013 The FSM SHALL have states ESP_A=2'b00, ESP_B=2'b01, MOSTRA=2'b10; 2'b11 SHALL be unreachable and, if entered, go to ESP_A next cycle.
REQ-014 ESP_A + press: fun_a <= sw, next state ESP_B; fun_b and valid unchanged.
REQ-015 ESP_B + press: fun_b <= sw, valid <= 1, timer <= 0, next state MOSTRA.
REQ-016 MOSTRA: timer SHALL increment each cycle; press OR timer == TIMEOUT_CYC-1 SHALL set valid <= 0 and next state ESP_A.
REQ-017 Press and timeout in the same cycle SHALL produce exactly one transition to ESP_A.
REQ-018 With TIMEOUT_CYC == 0, MOSTRA SHALL exit only on press.
REQ-019 fun_a and fun_b SHALL hold their values in all cases not listed above; sw changes without press SHALL NOT affect any output.
REQ-020 Timer width SHALL be clog2(TIMEOUT_CYC)+1 bits and SHALL never wrap.
REQ-021 valid SHALL be 1 only in MOSTRA; estado SHALL equal the registered state.

Reset
REQ-022 rst high SHALL immediately force state ESP_A, fun_a=3'b000, fun_b=3'b000, valid=0, timer=0, debounce counter=0.
REQ-023 Synchronizer and edge-history flops SHALL reset to 1, so a button held through reset release produces no press.
REQ-024 Reset asserted mid-sequence (ESP_B or MOSTRA) SHALL discard captured codes.

Configuration
REQ-025 Macro DEBOUNCE_EN defined: synchronized btn SHALL change the filtered level only after DEB_CYC consecutive cycles at the new value; press latency = REQ-012 + DEB_CYC cycles; glitches shorter than DEB_CYC SHALL be ignored.
REQ-026 Macro DEBOUNCE_EN undefined: no filter, DEB_CYC ignored, latency per REQ-012.

Structure
REQ-027 Package fun_pkg SHALL hold FUN_W=3 and the state enum (ESP_A, ESP_B, MOSTRA).
REQ-028 Synchronizer, optional debounce and edge detect SHALL live in sub-module deb_botao (btn in, one-cycle press out).

Verification
REQ-029 Reset, sw=3'b101, press, sw=3'b101, press -> fun_a=fun_b=3'b101, valid=1, estado=2'b10.
REQ-030 sw=3'b011 press, sw=3'b110 press -> fun_a=3'b011, fun_b=3'b110, valid=1; comparator out=0.
REQ-031 TIMEOUT_CYC=8, reach MOSTRA, no press -> valid drops and estado=2'b00 exactly 8 cycles after entering MOSTRA; codes held.
REQ-032 btn held high across rst release -> no transition, estado stays 2'b00 until release and re-press.
REQ-033 DEBOUNCE_EN, DEB_CYC=4: 3-cycle btn glitch -> no state change; 10-cycle press -> one transition.
REQ-034 rst asserted in ESP_B after fun_a=3'b111 -> fun_a=3'b000, estado=2'b00 same cycle.

Source files
------------

// File: rtl/fun_pkg.sv
// Shared types for the functionality-code entry block.
package fun_pkg;

  localparam int FUN_W = 3;

  typedef enum logic [1:0] {
    ESP_A  = 2'b00,
    ESP_B  = 2'b01,
    MOSTRA = 2'b10
  } estado_e;

endpackage

// File: rtl/deb_botao.sv
// Button conditioning: 2-flop sync, optional debounce, rising-edge press.
// Define DEBOUNCE_EN to insert the DEB_CYC stability filter.
module deb_botao #(
  parameter int DEB_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  logic s1_q;
  logic s2_q;
  logic hist_q;
  logic lvl;

  // Reset high so a button held through reset is not a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= btn_i;
      s2_q <= s1_q;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYC + 1);

  logic [CW-1:0] cnt_q;
  logic          filt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else if (s2_q == filt_q) begin
      cnt_q  <= '0;
    end else if (cnt_q == CW'(DEB_CYC - 1)) begin
      cnt_q  <= '0;
      filt_q <= s2_q;
    end else begin
      cnt_q  <= cnt_q + CW'(1);
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = s2_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist_q <= 1'b1;
    else     hist_q <= lvl;
  end

  assign press_o = lvl & ~hist_q;

endmodule

// File: rtl/entrada_fun.sv
// Two-step capture of functionality codes for the comparator.
// DEBOUNCE_EN enables the button debounce filter in deb_botao.
module entrada_fun
  import fun_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000,
  parameter int DEB_CYC     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [FUN_W-1:0] sw,
  input  logic             btn,
  output logic [FUN_W-1:0] fun_a,
  output logic [FUN_W-1:0] fun_b,
  output logic             valid,
  output logic [1:0]       estado
);

  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  estado_e          state_q;
  logic [FUN_W-1:0] fun_a_q;
  logic [FUN_W-1:0] fun_b_q;
  logic             valid_q;
  logic [TW-1:0]    timer_q;
  logic             press;
  logic             tmo;

  deb_botao #(
    .DEB_CYC (DEB_CYC)
  ) u_deb (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn),
    .press_o (press)
  );

  assign tmo = (TIMEOUT_CYC != 0) &&
               (timer_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ESP_A;
      fun_a_q <= '0;
      fun_b_q <= '0;
      valid_q <= 1'b0;
      timer_q <= '0;
    end else begin
      unique case (state_q)
        ESP_A: begin
          if (press) begin
            fun_a_q <= sw;
            state_q <= ESP_B;
          end
        end
        ESP_B: begin
          if (press) begin
            fun_b_q <= sw;
            valid_q <= 1'b1;
            timer_q <= '0;
            state_q <= MOSTRA;
          end
        end
        MOSTRA: begin
          if (press || tmo) begin
            valid_q <= 1'b0;
            state_q <= ESP_A;
          end else if (timer_q != '1) begin
            // Saturate so a zero timeout never wraps.
            timer_q <= timer_q + TW'(1);
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= ESP_A;
        end
      endcase
    end
  end

  assign fun_a  = fun_a_q;
  assign fun_b  = fun_b_q;
  assign valid  = valid_q;
  assign estado = state_q;

endmodule

// File: tb/tb_entrada_fun.sv
// Self-checking bench for entrada_fun (directed + randomized vs model).
module tb_entrada_fun;

  localparam int TO  = 8;
  localparam int DEB = 4;
`ifdef DEBOUNCE_EN
  localparam int LAT = 3 + DEB;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] sw;
  logic       btn;
  logic [2:0] fun_a;
  logic [2:0] fun_b;
  logic       valid;
  logic [1:0] estado;

  int errs = 0;
  int checks = 0;

  entrada_fun #(
    .TIMEOUT_CYC (TO),
    .DEB_CYC     (DEB)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sw     (sw),
    .btn    (btn),
    .fun_a  (fun_a),
    .fun_b  (fun_b),
    .valid  (valid),
    .estado (estado)
  );

  always #5 clk = ~clk;

  // Reference model: button level history -> presses -> capture rules.
  logic       rh [0:15];
  logic       fh [0:1];
  logic [1:0] m_st;
  logic [2:0] m_a;
  logic [2:0] m_b;
  logic       m_v;
  int         m_t;
  logic       pr;
  logic       fn;
  logic       same;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) rh[i] = 1'b1;
      fh[0] = 1'b1;
      fh[1] = 1'b1;
      m_st = 2'd0;
      m_a = 3'd0;
      m_b = 3'd0;
      m_v = 1'b0;
      m_t = 0;
    end else begin
      pr = fh[0] & ~fh[1];
`ifdef DEBOUNCE_EN
      same = 1'b1;
      for (int i = 2; i <= DEB; i++)
        if (rh[i] !== rh[1]) same = 1'b0;
      fn = same ? rh[1] : fh[0];
`else
      fn = rh[0];
`endif
      for (int i = 15; i > 0; i--) rh[i] = rh[i-1];
      rh[0] = btn;
      fh[1] = fh[0];
      fh[0] = fn;
      if (m_st == 2'd0) begin
        if (pr) begin m_a = sw; m_st = 2'd1; end
      end else if (m_st == 2'd1) begin
        if (pr) begin
          m_b = sw; m_v = 1'b1; m_t = 0; m_st = 2'd2;
        end
      end else begin
        if (pr || (m_t + 1 == TO)) begin
          m_v = 1'b0; m_st = 2'd0;
        end else begin
          m_t = m_t + 1;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; btn = 1'b0; sw = 3'b000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 2) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] v);
    @(negedge clk);
    sw = v; btn = 1'b1;
    repeat (LAT) @(posedge clk);
    #1;
  endtask

  task automatic release_btn();
    @(negedge clk);
    btn = 1'b0;
    repeat (LAT + 2) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({estado, valid, fun_a, fun_b} !== 9'd0) begin
      errs++;
      $display("FAIL reset_state got=%b%b%b%b exp=0",
               estado, valid, fun_a, fun_b);
    end
  endtask

  task automatic test_latency();
    do_reset();
    @(negedge clk);
    sw = 3'b010; btn = 1'b1;
    for (int e = 1; e <= LAT; e++) begin
      @(posedge clk); #1;
      checks++;
      if (estado !== ((e < LAT) ? 2'b00 : 2'b01)) begin
        errs++;
        $display("FAIL latency edge%0d got=%b", e, estado);
      end
    end
    release_btn();
  endtask

  task automatic test_same_codes();
    do_reset();
    press(3'b101); release_btn();
    press(3'b101);
    checks++;
    if ({fun_a, fun_b, valid, estado} !== 9'b101_101_1_10) begin
      errs++;
      $display("FAIL same_codes got=%b %b %b %b",
               fun_a, fun_b, valid, estado);
    end
    release_btn();
  endtask

  task automatic test_diff_codes();
    do_reset();
    press(3'b011); release_btn();
    press(3'b110);
    checks++;
    if ({fun_a, fun_b, valid} !== 7'b011_110_1) begin
      errs++;
      $display("FAIL diff_codes got=%b %b %b", fun_a, fun_b, valid);
    end
    checks++;
    if ((fun_a == fun_b) !== 1'b0) begin
      errs++;
      $display("FAIL diff_cmp got=1 exp=0");
    end
    release_btn();
  endtask

  task automatic test_timeout();
    do_reset();
    press(3'b001); release_btn();
    press(3'b100);
    checks++;
    if (estado !== 2'b10 || valid !== 1'b1) begin
      errs++;
      $display("FAIL tmo_enter got=%b %b", estado, valid);
    end
    for (int k = 1; k <= TO; k++) begin
      @(posedge clk); #1;
      checks++;
      if (estado !== ((k < TO) ? 2'b10 : 2'b00) ||
          valid !== (k < TO)) begin
        errs++;
        $display("FAIL tmo_cyc%0d got=%b %b", k, estado, valid);
      end
    end
    checks++;
    if (fun_a !== 3'b001 || fun_b !== 3'b100) begin
      errs++;
      $display("FAIL tmo_hold got=%b %b exp=001 100", fun_a, fun_b);
    end
    release_btn();
  endtask

  task automatic test_held_reset();
    @(negedge clk);
    btn = 1'b1; rst = 1'b1; sw = 3'b111;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < LAT + 8; k++) begin
      @(negedge clk);
      checks++;
      if (estado !== 2'b00) begin
        errs++;
        $display("FAIL held_rst cyc%0d got=%b exp=00", k, estado);
      end
    end
    release_btn();
    press(3'b110);
    checks++;
    if (estado !== 2'b01 || fun_a !== 3'b110) begin
      errs++;
      $display("FAIL held_repress got=%b %b", estado, fun_a);
    end
    release_btn();
  endtask

  task automatic test_sw_noise();
    do_reset();
    press(3'b010); release_btn();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      sw = 3'($urandom);
      #1;
      checks++;
      if ({estado, fun_a, fun_b, valid} !== 9'b01_010_000_0) begin
        errs++;
        $display("FAIL sw_noise got=%b %b %b %b",
                 estado, fun_a, fun_b, valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    press(3'b111); release_btn();
    checks++;
    if (estado !== 2'b01 || fun_a !== 3'b111) begin
      errs++;
      $display("FAIL mid_pre got=%b %b", estado, fun_a);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (estado !== 2'b00 || fun_a !== 3'b000) begin
      errs++;
      $display("FAIL mid_rst got=%b %b exp=00 000", estado, fun_a);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

`ifdef DEBOUNCE_EN
  task automatic test_glitch();
    do_reset();
    @(negedge clk);
    btn = 1'b1; sw = 3'b100;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (estado !== 2'b00) begin
      errs++;
      $display("FAIL glitch got=%b exp=00", estado);
    end
    btn = 1'b1;
    repeat (10) @(negedge clk);
    btn = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (estado !== 2'b01 || fun_a !== 3'b100) begin
      errs++;
      $display("FAIL long_press got=%b %b exp=01 100", estado, fun_a);
    end
  endtask
`endif

  task automatic test_random();
    int run;
    run = 0;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      checks++;
      if (estado !== m_st || fun_a !== m_a ||
          fun_b !== m_b || valid !== m_v) begin
        errs++;
        $display("FAIL rand c%0d got=%b %b %b %b exp=%b %b %b %b",
                 c, estado, fun_a, fun_b, valid,
                 m_st, m_a, m_b, m_v);
      end
      rst = 1'b0;
      sw = 3'($urandom);
      if (run == 0) begin
        btn = ~btn;
        run = $urandom_range(1, 12);
      end
      run--;
      if ($urandom_range(0, 299) == 0) rst = 1'b1;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; btn = 1'b0; sw = 3'b000;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_latency();
    test_same_codes();
    test_diff_codes();
    test_timeout();
    test_held_reset();
    test_sw_noise();
    test_reset_mid();
`ifdef DEBOUNCE_EN
    test_glitch();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
